// File: rtl/pipeline_ctrl_v2_pkg.sv
// pipeline_ctrl_v2_pkg: shared stall-bus layout, request indices and default masks
package pipeline_ctrl_v2_pkg;
  localparam int STALL_W = 6;
  localparam int NUM_REQ = 5;
  localparam int REQ_EX = 0;
  localparam int REQ_BRU = 1;
  localparam int REQ_CP0 = 2;
  localparam int REQ_LOAD = 3;
  localparam int REQ_FIFO = 4;
  typedef logic [STALL_W-1:0] stall_bus_t;
  localparam stall_bus_t MASK_EX = 6'b111101;
  localparam stall_bus_t MASK_BRU = 6'b001101;
  localparam stall_bus_t MASK_CP0 = 6'b001101;
  localparam stall_bus_t MASK_LOAD = 6'b000101;
  localparam stall_bus_t MASK_FIFO = 6'b000001;
  localparam logic [NUM_REQ*STALL_W-1:0] DEFAULT_MASKS = {MASK_FIFO, MASK_LOAD, MASK_CP0, MASK_BRU, MASK_EX};
  localparam int CP0_VALID_BIT = 32;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } cp0_to_ctrl_t;
endpackage

// File: rtl/pipeline_ctrl_v2_sat_counter.sv
// sat_counter: up-counter with synchronous clear that holds at MAX
module sat_counter #(
  parameter int W = 8,
  parameter logic [W-1:0] MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (inc && count_q != MAX) ? count_q + W'(1) : count_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/pipeline_ctrl_v2.sv
// pipeline_ctrl_v2: stall merge, CP0 redirect flush window, stall watchdog and perf counters
module pipeline_ctrl_v2 import pipeline_ctrl_v2_pkg::*; #(
  parameter int STAGES = STALL_W,
  parameter int NREQ = NUM_REQ,
  parameter logic [NREQ*STAGES-1:0] STALL_MASKS = DEFAULT_MASKS,
  parameter int PC_W = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   stall_req,
  input  logic              exc_valid,
  input  logic [PC_W-1:0]   exc_pc,
  input  logic              cnt_clr,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic              new_pc_valid,
  output logic [STAGES-1:0] stall,
  output logic              stall_timeout,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);
  localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam int RW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic stall_timeout_q, stall_timeout_d;
  logic [STAGES-1:0] stall_raw;
  logic [RW-1:0] run_cnt;
  logic stall_any;
  always_comb begin
    stall_raw = '0;
    for (int i = 0; i < NREQ; i++)
      stall_raw = stall_raw | (stall_req[i] ? STALL_MASKS[i*STAGES +: STAGES] : '0);
  end
  // outputs are forced quiet while reset is held, including the combinational paths
  assign new_pc_valid = exc_valid && !rst;
  assign new_pc = new_pc_valid ? exc_pc : '0;
  assign flush = new_pc_valid || flush_cnt_q != '0;
  assign stall = (flush || rst) ? '0 : stall_raw;
  assign stall_any = |stall;
  assign stall_timeout = stall_timeout_q;
  always_comb begin
    flush_cnt_d = exc_valid ? FW'(FLUSH_CYCLES - 1) : (flush_cnt_q != '0) ? flush_cnt_q - FW'(1) : flush_cnt_q;
    stall_timeout_d = cnt_clr ? 1'b0 : stall_timeout_q | (TIMEOUT != 0 && run_cnt == RW'(TIMEOUT));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flush_cnt_q <= '0;
      stall_timeout_q <= 1'b0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_timeout_q <= stall_timeout_d;
    end
  sat_counter #(.W(CNT_W)) u_stall_cycles (
    .clk(clk), .rst(rst), .inc(stall_any), .clr(cnt_clr), .count(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_events (
    .clk(clk), .rst(rst), .inc(exc_valid), .clr(cnt_clr), .count(flush_events)
  );
  sat_counter #(.W(RW), .MAX(RW'(TIMEOUT))) u_run_cnt (
    .clk(clk), .rst(rst), .inc(stall_any), .clr(cnt_clr || !stall_any), .count(run_cnt)
  );
endmodule

// File: tb/tb_pipeline_ctrl_v2.sv
// tb_pipeline_ctrl_v2: directed and random stimulus checked against a behavioural model
module tb_pipeline_ctrl_v2;
  localparam int FC = 3;
  localparam int TO = 4;
  localparam int CMAX = 15;
  logic clk = 0, rst = 1, exc_valid = 0, cnt_clr = 0;
  logic [4:0] stall_req = 5'b11111;
  logic [31:0] exc_pc = 0;
  logic flush, new_pc_valid, stall_timeout;
  logic [31:0] new_pc;
  logic [5:0] stall;
  logic [3:0] stall_cycles, flush_events;
  int n_chk = 0, n_fail = 0;
  int m_rem = 0, m_run = 0, m_sc = 0, m_fe = 0;
  bit m_to = 0;
  logic [5:0] mask_tab [5];

  pipeline_ctrl_v2 #(.FLUSH_CYCLES(FC), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .exc_valid(exc_valid), .exc_pc(exc_pc),
    .cnt_clr(cnt_clr), .flush(flush), .new_pc(new_pc), .new_pc_valid(new_pc_valid),
    .stall(stall), .stall_timeout(stall_timeout), .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] model_raw(input logic [4:0] r);
    logic [5:0] s = 0;
    for (int i = 0; i < 5; i++) if (r[i]) s |= mask_tab[i];
    return s;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_run = 0; m_sc = 0; m_fe = 0; m_to = 0;
  endtask

  task automatic check_regs();
    chk("stall_timeout", 32'(stall_timeout), 32'(m_to));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_sc));
    chk("flush_events", 32'(flush_events), 32'(m_fe));
  endtask

  task automatic step(input logic [4:0] req, input logic exc, input logic [31:0] pc, input logic clr);
    logic fl;
    logic [5:0] st;
    stall_req = req; exc_valid = exc; exc_pc = pc; cnt_clr = clr;
    #2;
    fl = exc || m_rem != 0;
    st = fl ? 6'b0 : model_raw(req);
    chk("stall", 32'(stall), 32'(st));
    chk("flush", 32'(flush), 32'(fl));
    chk("new_pc_valid", 32'(new_pc_valid), 32'(exc));
    chk("new_pc", new_pc, exc ? pc : 32'h0);
    check_regs();
    if (clr) begin
      m_sc = 0; m_fe = 0; m_run = 0; m_to = 0;
    end else begin
      if (m_run == TO) m_to = 1;
      m_run = st != 0 ? (m_run < TO ? m_run + 1 : TO) : 0;
      if (st != 0 && m_sc < CMAX) m_sc++;
      if (exc && m_fe < CMAX) m_fe++;
    end
    m_rem = exc ? FC - 1 : (m_rem > 0 ? m_rem - 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    mask_tab[0] = 6'b111101; mask_tab[1] = 6'b001101; mask_tab[2] = 6'b001101;
    mask_tab[3] = 6'b000101; mask_tab[4] = 6'b000001;
    @(negedge clk);
    exc_valid = 1; exc_pc = 32'hDEADBEEF;
    #2;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_new_pc_valid", 32'(new_pc_valid), 0);
    chk("rst_new_pc", new_pc, 0);
    check_regs();
    exc_valid = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) step(5'b11111, 0, 0, 0);
    chk("stall_cycles_after3", 32'(stall_cycles), 3);
    step(5'b01000, 0, 0, 0);
    step(5'b01001, 0, 0, 0);
    step(5'b10000, 0, 0, 0);
    step(5'b00000, 0, 0, 1);
    step(5'b00001, 1, 32'hBFC00380, 0);
    for (int i = 0; i < 4; i++) step(5'b00001, 0, 0, 0);
    chk("flush_events_one", 32'(flush_events), 1);
    step(5'b00001, 1, 32'h11111111, 0);
    step(5'b00001, 1, 32'h80000000, 0);
    for (int i = 0; i < 4; i++) step(5'b00001, 0, 0, 0);
    step(5'b00000, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(5'b00001, 0, 0, 0);
    chk("timeout_set", 32'(stall_timeout), 1);
    for (int i = 0; i < 3; i++) step(5'b00000, 0, 0, 0);
    step(5'b00001, 0, 0, 1);
    step(5'b00000, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(5'b00100, 0, 0, 0);
    step(5'b00100, 0, 0, 0);
    chk("stall_cycles_sat", 32'(stall_cycles), 32'hF);
    for (int i = 0; i < 300; i++)
      step(5'($urandom), $urandom_range(7) == 0, $urandom, $urandom_range(15) == 0);
    step(5'b00000, 1, 32'h80000180, 0);
    stall_req = 5'b00001; exc_valid = 0;
    #2;
    chk("flush_pre_rst", 32'(flush), 1);
    rst = 1;
    #1;
    chk("flush_async_rst", 32'(flush), 0);
    chk("stall_async_rst", 32'(stall), 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    step(5'b00001, 0, 0, 0);
    step(5'b00000, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl_v2.md
Name: pipeline_ctrl_v2

Overview:
Parametrised pipeline stall/flush controller for the in-order MIPS core.
- Merges NREQ stall-request sources into a per-stage stall vector, using a mask per source.
- Turns a CP0 exception/ERET redirect into a flush held for FLUSH_CYCLES, plus a one-cycle new-PC pulse.
- Adds a consecutive-stall watchdog and saturating performance counters.
- Sits beside CP0; drives stall/flush into every pipeline register.

Parameters:
- STAGES, 6, width of stall vector; bit 0 = PC/IF, ascending toward WB.
- NREQ, 5, number of stall-request sources.
- STALL_MASKS, {6'b000001,6'b000101,6'b001101,6'b001101,6'b111101}, NREQ*STAGES bits; the mask for source i is bits [i*STAGES +: STAGES]. Default order: i0=ex, i1=bru, i2=cp0, i3=load, i4=fifo.
- PC_W, 32, redirect PC width.
- FLUSH_CYCLES, 1, cycles flush stays high per redirect (>=1).
- TIMEOUT, 1024, consecutive stalled cycles before watchdog trips; 0 disables.
- CNT_W, 32, perf counter width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_req  in  NREQ  per-source stall request, level.
- exc_valid  in  1  CP0 redirect request (exception/ERET), single-cycle.
- exc_pc  in  PC_W  redirect target, qualified by exc_valid.
- cnt_clr  in  1  synchronous clear of counters and watchdog flag.
- flush  out  1  flush all pipeline registers.
- new_pc  out  PC_W  redirect PC, 0 when new_pc_valid=0.
- new_pc_valid  out  1  PC-register load strobe.
- stall  out  STAGES  per-stage hold.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  CNT_W  count of cycles with stall!=0.
- flush_events  out  CNT_W  count of cycles with exc_valid=1.

Behaviour:
- Reset:
  - While rst is high, all registers are 0.
  - flush, new_pc, new_pc_valid, stall, stall_timeout and both counters all read 0.
- Stall merge (combinational, zero latency):
  - stall_raw = bitwise OR of mask[i] over all i with stall_req[i]=1.
  - With nested default masks, this equals strict priority ex > bru|cp0 > load > fifo.
- stall = 0 when flush=1; otherwise stall = stall_raw. Flush overrides every stall request.
- Redirect (combinational, zero latency):
  - new_pc_valid = exc_valid.
  - new_pc = exc_valid ? exc_pc : 0.
- Flush FSM, encoded by register flush_cnt (IDLE: flush_cnt==0; FLUSH: flush_cnt!=0):
  - exc_valid=1 loads flush_cnt <= FLUSH_CYCLES-1, in any state (restart).
  - Otherwise, in FLUSH, flush_cnt decrements; returns to IDLE when it reaches 0.
  - flush = exc_valid | (flush_cnt!=0).
  - FLUSH_CYCLES=1 never leaves IDLE, so flush is the same cycle as exc_valid only.
  - A new exc_valid inside FLUSH: the latest PC is emitted and the window restarts from that cycle.
- Watchdog:
  - Register run_cnt increments each cycle with stall!=0 and saturates at TIMEOUT.
  - run_cnt clears to 0 on any cycle with stall==0, including cycles forced to 0 by flush.
  - When run_cnt reaches TIMEOUT, stall_timeout is set on the following edge and stays set until rst or cnt_clr.
  - TIMEOUT=0: flag never sets.
- Perf counters:
  - stall_cycles += 1 on each edge where stall!=0.
  - flush_events += 1 on each edge where exc_valid=1.
  - Both saturate at all-ones; no wrap.
- cnt_clr:
  - Sets both counters, run_cnt and stall_timeout to 0 on the next edge, taking priority over increments in the same cycle.
  - Does not affect flush_cnt.
- Reset asserted mid-flush: flush_cnt returns to 0 asynchronously and flush deasserts immediately.

Decomposition:
- Shared package (lib/defines.vh):
  - StallBus width.
  - Stall request index constants (REQ_EX, REQ_BRU, REQ_CP0, REQ_LOAD, REQ_FIFO).
  - Default per-source mask constants.
  - CP0_TO_CTRL bus layout: bit 32 = valid, [31:0] = PC.
- One natural sub-module: sat_counter (parameter W; inputs inc and clr, output count, saturating).
  - Instantiated for stall_cycles, flush_events and run_cnt (W=clog2(TIMEOUT+1)).

Test Plan:
- Reset released with stall_req=5'b11111 -> stall=6'b111101, flush=0, counters 0; after 3 cycles stall_cycles=3.
- stall_req=5'b01000 (load) -> stall=6'b000101. Add bit 0 (ex) -> 6'b111101. Only bit 4 -> 6'b000001.
- FLUSH_CYCLES=3, exc_valid one cycle with exc_pc=32'hBFC00380 while stall_req=5'b00001:
  - Same cycle: new_pc=BFC00380, new_pc_valid=1.
  - flush=1 for exactly 3 cycles; stall=0 throughout the window.
  - flush_events=1.
- FLUSH_CYCLES=3, second exc_valid (pc=32'h80000000) in flush cycle 2 -> new_pc=80000000 that cycle; flush stays high 3 further cycles (4 total).
- TIMEOUT=4, stall_req held at ex -> stall_timeout rises on 5th edge and stays set after stall_req drops; cnt_clr clears it and both counters to 0.
- Counters preloaded near all-ones (CNT_W=4), 20 stalled cycles -> stall_cycles holds at 4'hF; async rst mid-flush -> flush=0 immediately.
